// File: rtl/ysyx_icache_pkg.sv
// Shared geometry helpers and FSM state encoding for the direct-mapped instruction cache.
// Pure declarations: no logic, no latency, no backpressure.
package ysyx_icache_pkg;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_SETS       = 16;
    localparam int ICACHE_LINE_WORDS = 4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Bits [1:0] are the byte offset inside a word and never reach the tag.
    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - idx_w(sets) - off_w(line_words) - 2;
    endfunction

    localparam int ICACHE_OFF_W = off_w(ICACHE_LINE_WORDS);
    localparam int ICACHE_IDX_W = idx_w(ICACHE_SETS);
    localparam int ICACHE_TAG_W = tag_w(ICACHE_ADDR_W, ICACHE_SETS, ICACHE_LINE_WORDS);

endpackage

// File: rtl/ysyx_icache_if.sv
// Fetch-side and bus-side signals of the instruction cache; slave = cache, master = environment.
// Wires only: no latency, no backpressure of its own.
interface ysyx_icache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ifu_araddr;
    logic              ifu_arvalid;
    logic [DATA_W-1:0] ifu_rdata_o;
    logic              ifu_rvalid_o;
    logic              fence_i;
    logic [ADDR_W-1:0] bus_araddr_o;
    logic              bus_arvalid_o;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;

    modport slave (
        input  ifu_araddr, ifu_arvalid, fence_i, bus_rdata, bus_rvalid,
        output ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o, hit_cnt_o, miss_cnt_o
    );

    modport master (
        output ifu_araddr, ifu_arvalid, fence_i, bus_rdata, bus_rvalid,
        input  ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/ysyx_icache_array.sv
// Tag/valid/data storage: synchronous write port, combinational read port.
// Read has zero latency; writes land at the next edge; never stalls.
module ysyx_icache_array #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 26,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inval_i,
    input  logic                          we_i,
    input  logic [$clog2(SETS)-1:0]       widx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] woff_i,
    input  logic [DATA_W-1:0]             wdat_i,
    input  logic                          tag_we_i,
    input  logic [TAG_W-1:0]              wtag_i,
    input  logic                          set_vld_i,
    input  logic [$clog2(SETS)-1:0]       ridx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] roff_i,
    output logic [TAG_W-1:0]              rtag_o,
    output logic                          rvld_o,
    output logic [DATA_W-1:0]             rdat_o
);
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS*LINE_WORDS];

    // Invalidate wins over set so a flushed fill never becomes visible.
    always_ff @(posedge clk) begin
        if (rst || inval_i) begin
            valid_q <= '0;
        end else if (set_vld_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            data_q[{widx_i, woff_i}] <= wdat_i;
        end
        if (tag_we_i) begin
            tag_q[widx_i] <= wtag_i;
        end
    end

    assign rtag_o = tag_q[ridx_i];
    assign rvld_o = valid_q[ridx_i];
    assign rdat_o = data_q[{ridx_i, roff_i}];
endmodule

// File: rtl/ysyx_icache.sv
// Direct-mapped I-cache: 0-cycle hit, miss = 1 + LINE_WORDS bus beats + 1 hit cycle.
// The fetch side holds its request until ifu_rvalid_o; the fill holds bus_araddr_o until bus_rvalid.
module ysyx_icache
    import ysyx_icache_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int DATA_W     = ICACHE_DATA_W,
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input logic           clk,
    input logic           rst,
    ysyx_icache_if.slave  io
);
    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);

    logic [0:0]        state_q, state_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              flush_q, flush_d;
    logic [31:0]       hit_q, hit_d, miss_q, miss_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag, rd_tag;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_dat;
    logic [1:0]        unused_addr_lsb;
    logic              idle, hit, miss, beat_done, last_beat, inval, set_vld;

    assign req_off         = io.ifu_araddr[OFF_W+1:2];
    assign req_idx         = io.ifu_araddr[OFF_W+2 +: IDX_W];
    assign req_tag         = io.ifu_araddr[ADDR_W-1 -: TAG_W];
    assign unused_addr_lsb = io.ifu_araddr[1:0];
    assign fill_idx        = base_q[OFF_W+2 +: IDX_W];
    assign fill_tag        = base_q[ADDR_W-1 -: TAG_W];

    assign idle      = (state_q == S_IDLE);
    assign hit       = idle && io.ifu_arvalid && !io.fence_i && rd_vld && (rd_tag == req_tag);
    assign miss      = idle && io.ifu_arvalid && !io.fence_i && !(rd_vld && (rd_tag == req_tag));
    assign beat_done = (state_q == S_FILL) && io.bus_rvalid;
    assign last_beat = beat_done && (beat_q == OFF_W'(LINE_WORDS - 1));
    // A fence seen anywhere during the fill, including its last beat, discards the new line.
    assign inval     = (idle && io.fence_i) || (last_beat && (flush_q || io.fence_i));
    assign set_vld   = last_beat && !flush_q && !io.fence_i;

    ysyx_icache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .inval_i   (inval),
        .we_i      (beat_done),
        .widx_i    (fill_idx),
        .woff_i    (beat_q),
        .wdat_i    (io.bus_rdata),
        .tag_we_i  (last_beat),
        .wtag_i    (fill_tag),
        .set_vld_i (set_vld),
        .ridx_i    (req_idx),
        .roff_i    (req_off),
        .rtag_o    (rd_tag),
        .rvld_o    (rd_vld),
        .rdat_o    (rd_dat)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        flush_d = flush_q;
        hit_d   = hit ? hit_q + 32'd1 : hit_q;
        miss_d  = miss ? miss_q + 32'd1 : miss_q;
        if (miss) begin
            state_d = S_FILL;
            beat_d  = '0;
            base_d  = {io.ifu_araddr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
        if (state_q == S_FILL) begin
            if (io.fence_i) begin
                flush_d = 1'b1;
            end
            if (beat_done) begin
                beat_d = beat_q + OFF_W'(1);
            end
            if (last_beat) begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            flush_q <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            flush_q <= flush_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // rst gates the request combinationally so a reset mid-fill drops it in the same cycle.
    assign io.bus_arvalid_o = (state_q == S_FILL) && !rst;
    assign io.bus_araddr_o  = base_q | (ADDR_W'(beat_q) << 2);
    assign io.ifu_rvalid_o  = hit;
    assign io.ifu_rdata_o   = hit ? rd_dat : '0;
    assign io.hit_cnt_o     = hit_q;
    assign io.miss_cnt_o    = miss_q;
endmodule

// File: tb/tb_ysyx_icache.sv
// Directed bench for ysyx_icache: bench-side arbiter model plus a scoreboard of expected fetch data.
module tb_ysyx_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_hit  = 0;
    logic [31:0] exp_miss = 0;

    ysyx_icache_if #(.ADDR_W(32), .DATA_W(32)) ifu ();

    ysyx_icache #(.ADDR_W(32), .DATA_W(32), .SETS(16), .LINE_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifu)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk(tag, ifu.ifu_rdata_o, e);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_hit_cnt"}, ifu.hit_cnt_o, exp_hit);
        chk({tag, "_miss_cnt"}, ifu.miss_cnt_o, exp_miss);
    endtask

    // One fetch: a hit is checked in the request cycle; a miss is served beat by beat.
    // fence_beat >= 0 pulses fence_i on that beat and drops the request on the last beat.
    task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_hit_now,
                         input int stall_beat, input int stall_n, input int fence_beat);
        logic [31:0] base;
        base = addr & ~32'hF;
        if (exp_hit_now || fence_beat < 0) exp_q.push_back(mem(addr));
        @(negedge clk);
        ifu.ifu_arvalid = 1'b1;
        ifu.ifu_araddr  = addr;
        #1;
        if (exp_hit_now) begin
            chk({tag, "_hit_vld"}, 32'(ifu.ifu_rvalid_o), 32'd1);
            chk({tag, "_hit_nobus"}, 32'(ifu.bus_arvalid_o), 32'd0);
            pop_chk({tag, "_hit_dat"});
            exp_hit++;
        end else begin
            chk({tag, "_miss_vld"}, 32'(ifu.ifu_rvalid_o), 32'd0);
            exp_miss++;
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                #1;
                chk({tag, "_fill_arvld"}, 32'(ifu.bus_arvalid_o), 32'd1);
                chk({tag, "_fill_addr"}, ifu.bus_araddr_o, base + 32'(4 * b));
                chk({tag, "_fill_norv"}, 32'(ifu.ifu_rvalid_o), 32'd0);
                if (b == stall_beat) begin
                    for (int s = 0; s < stall_n; s++) begin
                        @(negedge clk);
                        #1;
                        chk({tag, "_stall_arvld"}, 32'(ifu.bus_arvalid_o), 32'd1);
                        chk({tag, "_stall_addr"}, ifu.bus_araddr_o, base + 32'(4 * b));
                    end
                end
                ifu.bus_rvalid = 1'b1;
                ifu.bus_rdata  = mem(base + 32'(4 * b));
                ifu.fence_i    = (b == fence_beat);
                if (fence_beat >= 0 && b == 3) ifu.ifu_arvalid = 1'b0;
                @(posedge clk);
                #1;
                ifu.bus_rvalid = 1'b0;
                ifu.bus_rdata  = '0;
                ifu.fence_i    = 1'b0;
            end
            @(negedge clk);
            #1;
            chk({tag, "_done_arvld"}, 32'(ifu.bus_arvalid_o), 32'd0);
            if (fence_beat < 0) begin
                chk({tag, "_refetch_vld"}, 32'(ifu.ifu_rvalid_o), 32'd1);
                pop_chk({tag, "_refetch_dat"});
                exp_hit++;
            end else begin
                chk({tag, "_flushed_vld"}, 32'(ifu.ifu_rvalid_o), 32'd0);
            end
        end
        @(negedge clk);
        ifu.ifu_arvalid = 1'b0;
        #1;
        chk_cnt(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifu.ifu_arvalid = 1'b0;
        ifu.ifu_araddr  = '0;
        ifu.fence_i     = 1'b0;
        ifu.bus_rvalid  = 1'b0;
        ifu.bus_rdata   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvld", 32'(ifu.bus_arvalid_o), 32'd0);
        chk("rst_rvld", 32'(ifu.ifu_rvalid_o), 32'd0);
        chk("rst_rdata", ifu.ifu_rdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_cnt("rst");

        fetch("cold", 32'h3000_0008, 1'b0, -1, 0, -1);
        fetch("warm", 32'h3000_000C, 1'b1, -1, 0, -1);
        fetch("evict", 32'h3000_0100, 1'b0, -1, 0, -1);
        fetch("reload", 32'h3000_0000, 1'b0, -1, 0, -1);
        fetch("stall", 32'h3000_0044, 1'b0, 1, 5, -1);
        fetch("stall_hit", 32'h3000_0040, 1'b1, -1, 0, -1);
        fetch("fence_fill", 32'h3000_0080, 1'b0, -1, 0, 2);
        fetch("after_fence", 32'h3000_0080, 1'b0, -1, 0, -1);
        fetch("all_cleared", 32'h3000_0040, 1'b0, -1, 0, -1);
        fetch("line0", 32'h3000_0000, 1'b0, -1, 0, -1);

        @(negedge clk);
        ifu.ifu_arvalid = 1'b1;
        ifu.ifu_araddr  = 32'h3000_0004;
        ifu.fence_i     = 1'b1;
        #1;
        chk("idle_fence_vld", 32'(ifu.ifu_rvalid_o), 32'd0);
        chk("idle_fence_dat", ifu.ifu_rdata_o, 32'd0);
        @(negedge clk);
        ifu.fence_i     = 1'b0;
        ifu.ifu_arvalid = 1'b0;
        #1;
        chk_cnt("idle_fence");
        fetch("post_idle_fence", 32'h3000_0004, 1'b0, -1, 0, -1);

        @(negedge clk);
        ifu.ifu_arvalid = 1'b1;
        ifu.ifu_araddr  = 32'h3000_00C0;
        @(negedge clk);
        #1;
        chk("rstfill_arvld", 32'(ifu.bus_arvalid_o), 32'd1);
        ifu.bus_rvalid = 1'b1;
        ifu.bus_rdata  = mem(32'h3000_00C0);
        @(posedge clk);
        #1;
        ifu.bus_rvalid = 1'b0;
        @(negedge clk);
        ifu.ifu_arvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstfill_drop", 32'(ifu.bus_arvalid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        #1;
        chk("rstfill_idle", 32'(ifu.bus_arvalid_o), 32'd0);
        chk_cnt("rstfill");
        fetch("post_rst", 32'h3000_00C0, 1'b0, -1, 0, -1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
